// File: rtl/pc_seq_pkg.sv
// pc_seq_pkg: shared definitions for the PC sequencer.
//   pc_seq_state_e : sequencer state encoding, also exported on the State port.
//   PC_INCR        : sequential fetch increment in bytes.
//   DBG_MODE_*     : DbgMode encodings sampled together with DbgStart.
package pc_seq_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RUN    = 3'd1,
    STEP   = 3'd2,
    DRAIN  = 3'd3,
    HALTED = 3'd4
  } pc_seq_state_e;

  localparam int unsigned PC_INCR = 4;

  localparam logic DBG_MODE_RUN  = 1'b0;
  localparam logic DBG_MODE_STEP = 1'b1;

endpackage

// File: rtl/pc_next_mux.sv
// pc_next_mux: combinational next-fetch-address selector.
// Priority: jump > taken branch > sequential (pc_current + PC_INCR, wrapping).
// Ports:
//   jump, jump_target       : jump resolved in ID and its destination
//   branch_taken, branch_target : taken branch resolved in ID and its destination
//   pc_current              : current PC register value
//   pc_next                 : selected next fetch address
module pc_next_mux
  import pc_seq_pkg::*;
#(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              jump,
  input  logic [ADDR_W-1:0] jump_target,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_target,
  input  logic [ADDR_W-1:0] pc_current,
  output logic [ADDR_W-1:0] pc_next
);

  always_comb begin
    pc_next = pc_current + ADDR_W'(PC_INCR);
    if (jump) begin
      pc_next = jump_target;
    end else if (branch_taken) begin
      pc_next = branch_target;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: sequences the PC register and the global pipeline advance.
// Debug modes: continuous run, single step (one advance per DbgStep rising edge)
// and a fixed-length pipeline drain after a HALT fetch, ending in HALTED.
// Ports:
//   Clock, Reset        : clock (rising edge), asynchronous active-high reset
//   DbgStart, DbgMode   : leave IDLE into RUN (mode 0) or STEP (mode 1)
//   DbgStep             : step request, rising edge detected internally
//   Stall               : load-use stall; blocks PC load and redirects
//   Jump, JumpTarget    : jump resolved in ID
//   BranchTaken, BranchTarget : taken branch resolved in ID
//   HaltDetected        : instruction at PC_Current is HALT
//   PC_Current          : PC register output
//   PC_Next, PC_Enable  : PC register data input and load enable
//   PipeEnable          : stage-register advance enable
//   Flush               : squash IF/ID
//   Halted, State       : status and state readback
// Optional build macro CYCLE_COUNTER_EN adds CycleCount, the number of advance
// cycles since reset (wraps at 2^32, holds in HALTED).
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int unsigned       ADDR_W       = 32,
  parameter logic [ADDR_W-1:0] RESET_PC     = '0,
  parameter int unsigned       DRAIN_CYCLES = 4
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              DbgStart,
  input  logic              DbgMode,
  input  logic              DbgStep,
  input  logic              Stall,
  input  logic              Jump,
  input  logic [ADDR_W-1:0] JumpTarget,
  input  logic              BranchTaken,
  input  logic [ADDR_W-1:0] BranchTarget,
  input  logic              HaltDetected,
  input  logic [ADDR_W-1:0] PC_Current,
  output logic [ADDR_W-1:0] PC_Next,
  output logic              PC_Enable,
  output logic              PipeEnable,
  output logic              Flush,
  output logic              Halted,
  output logic [2:0]        State
`ifdef CYCLE_COUNTER_EN
  ,
  output logic [31:0]       CycleCount
`endif
);

  localparam int unsigned CntW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  pc_seq_state_e   state_q;
  logic            step_prev_q;   // DbgStep from the previous clock
  logic            step_adv_q;    // a step edge was sampled: this cycle advances
  logic            drain_step_q;  // drain entered from STEP: drain advances on steps
  logic [CntW-1:0] drain_cnt_q;

  logic              step_rise;
  logic              adv;
  logic              fetch_halt;
  logic [ADDR_W-1:0] mux_pc;

  assign step_rise = DbgStep & ~step_prev_q;

  always_comb begin
    adv = 1'b0;
    case (state_q)
      RUN:     adv = 1'b1;
      STEP:    adv = step_adv_q;
      DRAIN:   adv = drain_step_q ? step_adv_q : 1'b1;
      default: adv = 1'b0;
    endcase
  end

  // A redirect or stall in the same cycle squashes the HALT fetch.
  assign fetch_halt = adv & ~Stall & ~Jump & ~BranchTaken & HaltDetected;

  pc_next_mux #(
    .ADDR_W(ADDR_W)
  ) u_pc_next_mux (
    .jump          (Jump),
    .jump_target   (JumpTarget),
    .branch_taken  (BranchTaken),
    .branch_target (BranchTarget),
    .pc_current    (PC_Current),
    .pc_next       (mux_pc)
  );

  assign PC_Next    = (state_q == IDLE) ? RESET_PC : mux_pc;
  assign PipeEnable = adv;
  assign PC_Enable  = adv & ~Stall & ((state_q == RUN) | (state_q == STEP));
  assign Flush      = adv & ~Stall & (Jump | BranchTaken);
  assign Halted     = (state_q == HALTED);
  assign State      = state_q;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q      <= IDLE;
      step_prev_q  <= 1'b0;
      step_adv_q   <= 1'b0;
      drain_step_q <= 1'b0;
      drain_cnt_q  <= '0;
    end else begin
      step_prev_q <= DbgStep;
      step_adv_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (DbgStart) begin
            case (DbgMode)
              DBG_MODE_RUN:  state_q <= RUN;
              DBG_MODE_STEP: state_q <= STEP;
              default:       state_q <= IDLE;
            endcase
          end
        end
        RUN: begin
          if (fetch_halt) begin
            state_q      <= DRAIN;
            drain_step_q <= 1'b0;
            drain_cnt_q  <= CntW'(DRAIN_CYCLES - 1);
          end
        end
        STEP: begin
          step_adv_q <= step_rise;
          if (fetch_halt) begin
            state_q      <= DRAIN;
            drain_step_q <= 1'b1;
            drain_cnt_q  <= CntW'(DRAIN_CYCLES - 1);
          end
        end
        DRAIN: begin
          step_adv_q <= drain_step_q & step_rise;
          if (adv) begin
            if (drain_cnt_q == '0) begin
              state_q <= HALTED;
            end else begin
              drain_cnt_q <= drain_cnt_q - CntW'(1);
            end
          end
        end
        HALTED: begin
          state_q <= HALTED;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

`ifdef CYCLE_COUNTER_EN
  logic [31:0] cycle_q;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      cycle_q <= '0;
    end else if (adv) begin
      cycle_q <= cycle_q + 32'd1;
    end
  end

  assign CycleCount = cycle_q;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: self-checking bench for pc_sequencer.
// Directed vector table in RUN, hand sequences for halt drain, step edges and
// asynchronous reset, then randomized traffic against a behavioural model.
module tb_pc_sequencer;

  localparam int S_IDLE = 0, S_RUN = 1, S_STEP = 2, S_DRAIN = 3, S_HALTED = 4;
  localparam int DRAIN_N = 4;

  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic        DbgStart = 1'b0, DbgMode = 1'b0, DbgStep = 1'b0, Stall = 1'b0;
  logic        Jump = 1'b0, BranchTaken = 1'b0, HaltDetected = 1'b0;
  logic [31:0] JumpTarget = '0, BranchTarget = '0, PC_Current = '0;
  logic [31:0] PC_Next;
  logic        PC_Enable, PipeEnable, Flush, Halted;
  logic [2:0]  State;
`ifdef CYCLE_COUNTER_EN
  logic [31:0] CycleCount;
`endif

  pc_sequencer #(
    .ADDR_W       (32),
    .RESET_PC     (32'h0000_0000),
    .DRAIN_CYCLES (DRAIN_N)
  ) dut (
    .Clock        (Clock),
    .Reset        (Reset),
    .DbgStart     (DbgStart),
    .DbgMode      (DbgMode),
    .DbgStep      (DbgStep),
    .Stall        (Stall),
    .Jump         (Jump),
    .JumpTarget   (JumpTarget),
    .BranchTaken  (BranchTaken),
    .BranchTarget (BranchTarget),
    .HaltDetected (HaltDetected),
    .PC_Current   (PC_Current),
    .PC_Next      (PC_Next),
    .PC_Enable    (PC_Enable),
    .PipeEnable   (PipeEnable),
    .Flush        (Flush),
    .Halted       (Halted),
    .State        (State)
`ifdef CYCLE_COUNTER_EN
    ,
    .CycleCount   (CycleCount)
`endif
  );

  always #5 Clock = ~Clock;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic clear_inputs();
    DbgStart = 0; DbgStep = 0; Stall = 0; Jump = 0; BranchTaken = 0; HaltDetected = 0;
  endtask

  // Directed RUN-mode vectors.
  typedef struct {
    logic        stall, jump, branch, halt;
    logic [31:0] pc, jt, bt;
    logic [31:0] exp_next;
    logic        exp_en, exp_flush;
  } vec_t;
  vec_t vecs[8];

  // Step-edge table: DbgStep level per cycle and the PipeEnable expected then.
  typedef struct {
    logic step;
    logic exp_pe;
  } step_vec_t;
  step_vec_t svecs[10];

  // Behavioural reference model.
  int          m_st, m_left;
  bit          m_prev, m_pend, m_dstep;
  logic [31:0] m_cyc, m_pc;
  logic        e_adv, e_en, e_flush;
  logic [31:0] e_next;

  task automatic m_reset();
    m_st = S_IDLE; m_left = 0; m_prev = 0; m_pend = 0; m_dstep = 0; m_cyc = 0; m_pc = 0;
  endtask

  task automatic m_expect();
    case (m_st)
      S_RUN:   e_adv = 1;
      S_STEP:  e_adv = m_pend;
      S_DRAIN: e_adv = m_dstep ? m_pend : 1'b1;
      default: e_adv = 0;
    endcase
    e_en    = e_adv && !Stall && (m_st == S_RUN || m_st == S_STEP);
    e_flush = e_adv && !Stall && (Jump || BranchTaken);
    if (m_st == S_IDLE) e_next = 32'h0;
    else if (Jump)      e_next = JumpTarget;
    else if (BranchTaken) e_next = BranchTarget;
    else                e_next = PC_Current + 32'd4;
  endtask

  task automatic m_advance();
    bit rise, pend_n;
    rise   = DbgStep && !m_prev;
    pend_n = rise && (m_st == S_STEP || (m_st == S_DRAIN && m_dstep));
    if (e_adv) m_cyc = m_cyc + 1;
    if (e_en) m_pc = e_next;
    case (m_st)
      S_IDLE: if (DbgStart) m_st = DbgMode ? S_STEP : S_RUN;
      S_RUN, S_STEP:
        if (e_adv && !Stall && !Jump && !BranchTaken && HaltDetected) begin
          m_dstep = (m_st == S_STEP);
          m_left  = DRAIN_N;
          m_st    = S_DRAIN;
        end
      S_DRAIN:
        if (e_adv) begin
          m_left--;
          if (m_left == 0) m_st = S_HALTED;
        end
      default: ;
    endcase
    m_prev = DbgStep;
    m_pend = pend_n;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] pc_env;
    int          halted_cnt;

    vecs[0] = '{0, 0, 0, 0, 32'h10,       32'h0,   32'h0,   32'h14,    1, 0};
    vecs[1] = '{0, 0, 0, 0, 32'hFFFFFFFC, 32'h0,   32'h0,   32'h0,     1, 0};
    vecs[2] = '{0, 1, 1, 0, 32'h10,       32'h200, 32'h100, 32'h200,   1, 1};
    vecs[3] = '{1, 1, 1, 0, 32'h10,       32'h200, 32'h100, 32'h200,   0, 0};
    vecs[4] = '{0, 0, 1, 0, 32'h20,       32'h0,   32'h100, 32'h100,   1, 1};
    vecs[5] = '{0, 0, 1, 1, 32'h40,       32'h0,   32'h80,  32'h80,    1, 1};
    vecs[6] = '{1, 0, 0, 1, 32'h40,       32'h0,   32'h0,   32'h44,    0, 0};
    vecs[7] = '{0, 1, 0, 1, 32'h40,       32'h300, 32'h0,   32'h300,   1, 1};

    svecs[0] = '{1, 0}; svecs[1] = '{1, 1}; svecs[2] = '{1, 0}; svecs[3] = '{1, 0};
    svecs[4] = '{1, 0}; svecs[5] = '{0, 0}; svecs[6] = '{0, 0}; svecs[7] = '{1, 0};
    svecs[8] = '{0, 1}; svecs[9] = '{0, 0};

    // Reset state.
    repeat (2) @(negedge Clock);
    #1;
    check("rst_state", State, S_IDLE);
    check("rst_pipe", PipeEnable, 0);
    check("rst_pc_en", PC_Enable, 0);
    check("rst_flush", Flush, 0);
    check("rst_halted", Halted, 0);
    check("rst_pc_next", PC_Next, 32'h0);
`ifdef CYCLE_COUNTER_EN
    check("rst_cycles", CycleCount, 0);
`endif

    // Start RUN: PC_Enable one clock after DbgStart.
    @(negedge Clock); Reset = 0; DbgStart = 1; DbgMode = 0; PC_Current = 32'h10;
    #1;
    check("start_pc_en", PC_Enable, 0);
    check("start_pc_next_idle", PC_Next, 32'h0);
    @(negedge Clock); DbgStart = 0;
    #1;
    check("run_state", State, S_RUN);
    check("run_pc_en", PC_Enable, 1);

    for (int i = 0; i < 8; i++) begin
      @(negedge Clock);
      Stall = vecs[i].stall; Jump = vecs[i].jump; BranchTaken = vecs[i].branch;
      HaltDetected = vecs[i].halt; PC_Current = vecs[i].pc;
      JumpTarget = vecs[i].jt; BranchTarget = vecs[i].bt;
      #1;
      check($sformatf("vec%0d_state", i), State, S_RUN);
      check($sformatf("vec%0d_pc_next", i), PC_Next, vecs[i].exp_next);
      check($sformatf("vec%0d_pc_en", i), PC_Enable, vecs[i].exp_en);
      check($sformatf("vec%0d_flush", i), Flush, vecs[i].exp_flush);
      check($sformatf("vec%0d_pipe", i), PipeEnable, 1);
    end

    // HALT fetch in RUN: four drain advances, then HALTED with the PC frozen.
    @(negedge Clock); clear_inputs(); PC_Current = 32'h40; HaltDetected = 1;
    #1;
    check("halt_pc_en", PC_Enable, 1);
    check("halt_pc_next", PC_Next, 32'h44);
    pc_env = 32'h40;
    if (PC_Enable) pc_env = PC_Next;
    for (int d = 0; d < DRAIN_N; d++) begin
      @(negedge Clock); PC_Current = pc_env;
      #1;
      check($sformatf("drain%0d_state", d), State, S_DRAIN);
      check($sformatf("drain%0d_pipe", d), PipeEnable, 1);
      check($sformatf("drain%0d_pc_en", d), PC_Enable, 0);
      if (PC_Enable) pc_env = PC_Next;
    end
    @(negedge Clock); PC_Current = pc_env;
    #1;
    check("halted_state", State, S_HALTED);
    check("halted_flag", Halted, 1);
    check("halted_pipe", PipeEnable, 0);
    check("halted_pc_hold", pc_env, 32'h44);
    @(negedge Clock); DbgStart = 1; DbgStep = 1;
    @(negedge Clock); DbgStart = 0; DbgStep = 0;
    #1;
    check("halted_ignore_start", State, S_HALTED);
    check("halted_ignore_pc_en", PC_Enable, 0);

    // Asynchronous reset in the middle of RUN.
    @(negedge Clock); Reset = 1; clear_inputs();
    @(negedge Clock); Reset = 0; DbgStart = 1; DbgMode = 0; PC_Current = 32'h100;
    @(negedge Clock); DbgStart = 0;
    repeat (2) @(negedge Clock);
    @(posedge Clock); #2; Reset = 1; #1;
    check("async_rst_state", State, S_IDLE);
    check("async_rst_pipe", PipeEnable, 0);
    check("async_rst_halted", Halted, 0);
    check("async_rst_pc_next", PC_Next, 32'h0);

    // STEP mode: one advance per DbgStep rising edge, one clock after it.
    @(negedge Clock); Reset = 0; DbgStart = 1; DbgMode = 1; PC_Current = 32'h60;
    @(negedge Clock); DbgStart = 0;
    #1;
    check("step_state", State, S_STEP);
    check("step_idle_pipe", PipeEnable, 0);
    for (int i = 0; i < 10; i++) begin
      @(negedge Clock); DbgStep = svecs[i].step;
      #1;
      check($sformatf("step%0d_pipe", i), PipeEnable, svecs[i].exp_pe);
      check($sformatf("step%0d_pc_en", i), PC_Enable, svecs[i].exp_pe);
    end
`ifdef CYCLE_COUNTER_EN
    check("step_cycles", CycleCount, 2);
`endif

    // HALT accepted in STEP: the drain advances only on further step edges.
    @(negedge Clock); DbgStep = 1;
    #1; check("sdrain_edge_pipe", PipeEnable, 0);
    @(negedge Clock); DbgStep = 0; HaltDetected = 1;
    #1; check("sdrain_fetch_pipe", PipeEnable, 1);
    @(negedge Clock);
    #1;
    check("sdrain_state", State, S_DRAIN);
    check("sdrain_wait_pipe", PipeEnable, 0);
    for (int k = 0; k < DRAIN_N; k++) begin
      @(negedge Clock); DbgStep = 1;
      #1; check($sformatf("sdrain%0d_edge_pipe", k), PipeEnable, 0);
      @(negedge Clock); DbgStep = 0;
      #1;
      check($sformatf("sdrain%0d_pipe", k), PipeEnable, 1);
      check($sformatf("sdrain%0d_pc_en", k), PC_Enable, 0);
    end
    @(negedge Clock);
    #1;
    check("sdrain_halted", Halted, 1);
`ifdef CYCLE_COUNTER_EN
    check("sdrain_cycles", CycleCount, 7);
`endif
    @(negedge Clock); DbgStep = 1;
    @(negedge Clock); DbgStep = 0;
    #1;
    check("sdrain_halted_pipe", PipeEnable, 0);
    check("sdrain_halted_state", State, S_HALTED);

    // Randomized traffic against the reference model.
    @(negedge Clock); Reset = 1; clear_inputs();
    m_reset();
    halted_cnt = 0;
    for (int c = 0; c < 4000; c++) begin
      @(negedge Clock);
      Reset = 0;
      if (m_st == S_IDLE) DbgStart = ($urandom_range(0, 3) == 0);
      else                DbgStart = ($urandom_range(0, 7) == 0);
      DbgMode      = 1'($urandom_range(0, 1));
      DbgStep      = 1'($urandom_range(0, 1));
      Stall        = ($urandom_range(0, 4) == 0);
      Jump         = ($urandom_range(0, 7) == 0);
      BranchTaken  = ($urandom_range(0, 7) == 0);
      HaltDetected = ($urandom_range(0, 15) == 0);
      JumpTarget   = $urandom() & 32'hFFFF_FFFC;
      BranchTarget = $urandom() & 32'hFFFF_FFFC;
      if ($urandom_range(0, 49) == 0) m_pc = 32'hFFFF_FFFC;
      PC_Current = m_pc;
      if ($urandom_range(0, 149) == 0 || halted_cnt > 6) begin
        Reset = 1;
        #1;
        m_reset();
        halted_cnt = 0;
        check("rnd_rst_state", State, S_IDLE);
        check("rnd_rst_pipe", PipeEnable, 0);
      end else begin
        m_expect();
        #1;
        check("rnd_state", State, m_st);
        check("rnd_pipe", PipeEnable, e_adv);
        check("rnd_pc_en", PC_Enable, e_en);
        check("rnd_flush", Flush, e_flush);
        check("rnd_pc_next", PC_Next, e_next);
        check("rnd_halted", Halted, m_st == S_HALTED);
`ifdef CYCLE_COUNTER_EN
        check("rnd_cycles", CycleCount, m_cyc);
`endif
        m_advance();
        if (m_st == S_HALTED) halted_cnt++;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
